// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder: monitors the r/g/b outputs of an LED sequencer and recovers the
// pattern class (shift/flash/mirror), shift direction, step period and active colour.
module led_pattern_decoder #(
  parameter int N_LEDS    = 4,
  parameter int NB_PERIOD = 32,
  parameter int N_CONFIRM = 2
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic [N_LEDS-1:0]    i_led_r,
  input  logic [N_LEDS-1:0]    i_led_g,
  input  logic [N_LEDS-1:0]    i_led_b,
  output logic                 o_valid,
  output logic [1:0]           o_mode,
  output logic                 o_dir,
  output logic [NB_PERIOD-1:0] o_period,
  output logic [2:0]           o_color,
  output logic                 o_error
);

  typedef enum logic [1:0] {
    MODE_SHIFT   = 2'd0,
    MODE_FLASH   = 2'd1,
    MODE_MIRROR  = 2'd2,
    MODE_UNKNOWN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  typedef struct packed {
    mode_e                mode;
    logic                 dir;
    logic [NB_PERIOD-1:0] period;
  } cand_t;

  localparam int                   CW          = (N_CONFIRM < 2) ? 1 : $clog2(N_CONFIRM + 1);
  localparam logic [CW-1:0]        CONF_ONE    = CW'(1);
  localparam logic [CW-1:0]        CONF_TARGET = CW'(N_CONFIRM);
  localparam logic [NB_PERIOD-1:0] CNT_ONE     = NB_PERIOD'(1);
  localparam logic [NB_PERIOD-1:0] CNT_MAX     = '1;

  // Sampled inputs
  logic [N_LEDS-1:0]    r_s;
  logic [N_LEDS-1:0]    r_prev;
  logic [2:0]           r_col;
  logic [NB_PERIOD-1:0] r_cnt;
  logic [2:0]           r_color;

  // FSM and registered outputs
  state_e               r_state;
  logic                 r_have_cand;
  cand_t                r_cand;
  logic [CW-1:0]        r_confirm;
  logic                 r_valid;
  mode_e                r_mode;
  logic                 r_dir;
  logic [NB_PERIOD-1:0] r_period;
  logic                 r_error;

  state_e               w_state_nxt;
  logic                 w_have_cand_nxt;
  cand_t                w_cand_nxt;
  logic [CW-1:0]        w_confirm_nxt;
  logic                 w_valid_nxt;
  mode_e                w_mode_nxt;
  logic                 w_dir_nxt;
  logic [NB_PERIOD-1:0] w_period_nxt;
  logic                 w_error_nxt;

  logic [N_LEDS-1:0]    w_rotl;
  logic [N_LEDS-1:0]    w_rotr;
  logic [N_LEDS-1:0]    w_rev_prev;
  logic [N_LEDS-1:0]    w_rev_s;
  logic                 w_change;
  logic                 w_timeout;
  logic                 w_shift_ok;
  logic                 w_flash;
  logic                 w_mirror_ok;
  mode_e                w_class;
  logic                 w_dir;
  logic                 w_consistent;

  // NOTE: every clocked register uses <= so all flops see pre-edge values, independent of
  // the order the always_ff blocks are evaluated in.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_s    <= '0;
      r_prev <= '0;
      r_col  <= '0;
    end else begin
      r_s    <= i_led_r | i_led_g | i_led_b;
      r_col  <= {|i_led_b, |i_led_g, |i_led_r};
      r_prev <= r_s;
    end
  end

  assign w_change = (r_s != r_prev);

  // Counts clocks since the last pattern change; its value on a change cycle is the interval.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_change) begin
      r_cnt <= CNT_ONE;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_color <= '0;
    end else if (r_s != '0) begin
      r_color <= r_col;
    end
  end

  generate
    if (N_LEDS > 1) begin : g_rot
      assign w_rotl = {r_prev[N_LEDS-2:0], r_prev[N_LEDS-1]};
      assign w_rotr = {r_prev[0], r_prev[N_LEDS-1:1]};
    end else begin : g_no_rot
      assign w_rotl = r_prev;
      assign w_rotr = r_prev;
    end
  endgenerate

  assign w_rev_prev  = {<<{r_prev}};
  assign w_rev_s     = {<<{r_s}};
  assign w_shift_ok  = (N_LEDS > 1) && $onehot(r_prev) && $onehot(r_s);
  assign w_flash     = ((r_prev == '0) && (r_s == '1)) || ((r_prev == '1) && (r_s == '0));
  assign w_mirror_ok = (r_prev == w_rev_prev) && (r_s == w_rev_s) &&
                       ($countones(r_prev) <= 2) && ($countones(r_s) <= 2);

  // NOTE: each output of a combinational block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_class = MODE_UNKNOWN;
    w_dir   = 1'b0;
    if (w_shift_ok && (r_s == w_rotl)) begin
      w_class = MODE_SHIFT;
      w_dir   = 1'b1;
    end else if (w_shift_ok && (r_s == w_rotr)) begin
      w_class = MODE_SHIFT;
    end else if (w_flash) begin
      w_class = MODE_FLASH;
    end else if (w_mirror_ok) begin
      w_class = MODE_MIRROR;
    end
  end

  assign w_consistent = r_have_cand && (w_class != MODE_UNKNOWN) &&
                        (w_class == r_cand.mode) && (w_dir == r_cand.dir) &&
                        (r_cnt == r_cand.period);
  assign w_timeout    = (r_cnt == CNT_MAX) && (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt     = r_state;
    w_have_cand_nxt = r_have_cand;
    w_cand_nxt      = r_cand;
    w_confirm_nxt   = r_confirm;
    w_valid_nxt     = r_valid;
    w_mode_nxt      = r_mode;
    w_dir_nxt       = r_dir;
    w_period_nxt    = r_period;
    w_error_nxt     = 1'b0;

    if (w_timeout) begin
      w_state_nxt     = ST_IDLE;
      w_have_cand_nxt = 1'b0;
      w_confirm_nxt   = '0;
      w_valid_nxt     = 1'b0;
      w_mode_nxt      = MODE_UNKNOWN;
      w_error_nxt     = (r_state == ST_LOCK);
    end else if (w_change) begin
      unique case (r_state)
        ST_IDLE: begin
          // The first change has no meaningful interval behind it, so nothing is loaded.
          w_state_nxt     = ST_ACQ;
          w_have_cand_nxt = 1'b0;
          w_confirm_nxt   = '0;
        end
        ST_ACQ: begin
          if (w_consistent) begin
            w_confirm_nxt = r_confirm + CONF_ONE;
            if (w_confirm_nxt == CONF_TARGET) begin
              w_state_nxt  = ST_LOCK;
              w_valid_nxt  = 1'b1;
              w_mode_nxt   = r_cand.mode;
              w_dir_nxt    = r_cand.dir;
              w_period_nxt = r_cand.period;
            end
          end else begin
            w_have_cand_nxt   = 1'b1;
            w_cand_nxt.mode   = w_class;
            w_cand_nxt.dir    = w_dir;
            w_cand_nxt.period = r_cnt;
            w_confirm_nxt     = '0;
          end
        end
        ST_LOCK: begin
          if (!w_consistent) begin
            w_state_nxt       = ST_ACQ;
            w_error_nxt       = 1'b1;
            w_valid_nxt       = 1'b0;
            w_mode_nxt        = MODE_UNKNOWN;
            w_have_cand_nxt   = 1'b1;
            w_cand_nxt.mode   = w_class;
            w_cand_nxt.dir    = w_dir;
            w_cand_nxt.period = r_cnt;
            w_confirm_nxt     = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_have_cand <= 1'b0;
      r_cand      <= '0;
      r_confirm   <= '0;
      r_valid     <= 1'b0;
      r_mode      <= MODE_UNKNOWN;
      r_dir       <= 1'b0;
      r_period    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_have_cand <= w_have_cand_nxt;
      r_cand      <= w_cand_nxt;
      r_confirm   <= w_confirm_nxt;
      r_valid     <= w_valid_nxt;
      r_mode      <= w_mode_nxt;
      r_dir       <= w_dir_nxt;
      r_period    <= w_period_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign o_valid  = r_valid;
  assign o_mode   = r_mode;
  assign o_dir    = r_dir;
  assign o_period = r_period;
  assign o_color  = r_color;
  assign o_error  = r_error;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Bench for led_pattern_decoder: directed scenarios plus random runs, checked every clock
// against a timestamp-based reference model, on a 32-bit and an 8-bit period instance.
module tb_led_pattern_decoder;

  localparam int NC = 2;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [3:0] led_r, led_g, led_b;

  logic        v32, d32, e32, v8, d8, e8;
  logic [1:0]  m32, m8;
  logic [31:0] p32;
  logic [7:0]  p8;
  logic [2:0]  c32, c8;

  always #5 clk = ~clk;

  led_pattern_decoder #(.N_LEDS(4), .NB_PERIOD(32), .N_CONFIRM(NC)) u_dut32 (
    .clock(clk), .i_reset(i_reset), .i_led_r(led_r), .i_led_g(led_g), .i_led_b(led_b),
    .o_valid(v32), .o_mode(m32), .o_dir(d32), .o_period(p32), .o_color(c32), .o_error(e32)
  );

  led_pattern_decoder #(.N_LEDS(4), .NB_PERIOD(8), .N_CONFIRM(NC)) u_dut8 (
    .clock(clk), .i_reset(i_reset), .i_led_r(led_r), .i_led_g(led_g), .i_led_b(led_b),
    .o_valid(v8), .o_mode(m8), .o_dir(d8), .o_period(p8), .o_color(c8), .o_error(e8)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint tick_n   = 0;
  int     pend_s   = 0;
  int     pend_col = 0;
  int     err32    = 0;
  int     err8     = 0;

  // Reference model: index 0 is the 32-bit instance, index 1 the 8-bit one.
  longint m_max[2] = '{64'hFFFF_FFFF, 64'd255};
  int     m_prev;
  longint m_last;
  int     m_phase[2];   // 0 idle, 1 acquiring, 2 locked
  int     m_run[2];     // identical transitions seen since the candidate was taken
  int     m_ccls[2];
  int     m_cdir[2];
  longint m_cint[2];
  bit     m_fresh[2];
  int     e_valid[2], e_mode[2], e_dir[2], e_error[2];
  longint e_period[2];
  int     e_color;
  int     mir[3] = '{9, 6, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_pos(input int x);
    for (int i = 0; i < 4; i++) if (x == (1 << i)) return i;
    return -1;
  endfunction

  task automatic classify(input int p, input int s, output int cls, output int d);
    int ip, is;
    ip  = bit_pos(p);
    is  = bit_pos(s);
    d   = 0;
    cls = 3;
    if (ip >= 0 && is >= 0 && is == (ip + 1) % 4) begin
      cls = 0;
      d   = 1;
    end else if (ip >= 0 && is >= 0 && ip == (is + 1) % 4) begin
      cls = 0;
    end else if ((p == 0 && s == 15) || (p == 15 && s == 0)) begin
      cls = 1;
    end else if ((p == 0 || p == 9 || p == 6) && (s == 0 || s == 9 || s == 6)) begin
      cls = 2;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k]  = 0;
      m_run[k]    = 0;
      m_fresh[k]  = 1'b1;
      e_valid[k]  = 0;
      e_mode[k]   = 3;
      e_dir[k]    = 0;
      e_period[k] = 0;
      e_error[k]  = 0;
    end
    e_color = 0;
    m_prev  = 0;
    m_last  = tick_n;
  endtask

  task automatic model_step(input int s, input int col, input longint j);
    int     cls, d;
    longint iv;
    bit     chg;
    cls = 3;
    d   = 0;
    chg = (s != m_prev);
    if (s != 0) e_color = col;
    if (chg) classify(m_prev, s, cls, d);
    for (int k = 0; k < 2; k++) begin
      e_error[k] = 0;
      iv = j - m_last;
      if (iv > m_max[k]) iv = m_max[k];
      if (m_phase[k] != 0 && (j - m_last) >= m_max[k]) begin
        if (m_phase[k] == 2) e_error[k] = 1;
        m_phase[k] = 0;
        m_run[k]   = 0;
        e_valid[k] = 0;
        e_mode[k]  = 3;
      end else if (chg) begin
        if (m_phase[k] == 0) begin
          m_phase[k] = 1;
          m_run[k]   = 0;
        end else if (m_run[k] > 0 && cls != 3 && cls == m_ccls[k] && d == m_cdir[k] &&
                     iv == m_cint[k]) begin
          if (m_phase[k] == 1) begin
            m_run[k]++;
            if (m_run[k] == NC + 1) begin
              m_phase[k]  = 2;
              m_fresh[k]  = 1'b0;
              e_valid[k]  = 1;
              e_mode[k]   = m_ccls[k];
              e_dir[k]    = m_cdir[k];
              e_period[k] = m_cint[k];
            end
          end
        end else begin
          if (m_phase[k] == 2) begin
            e_error[k] = 1;
            e_valid[k] = 0;
            e_mode[k]  = 3;
          end
          m_phase[k] = 1;
          m_run[k]   = 1;
          m_ccls[k]  = cls;
          m_cdir[k]  = d;
          m_cint[k]  = iv;
        end
      end
    end
    if (chg) m_last = j;
    m_prev = s;
  endtask

  task automatic check_all();
    check($sformatf("t%0d valid32", tick_n), 32'(v32), 32'(e_valid[0]));
    check($sformatf("t%0d mode32", tick_n),  32'(m32), 32'(e_mode[0]));
    check($sformatf("t%0d color32", tick_n), 32'(c32), 32'(e_color));
    check($sformatf("t%0d error32", tick_n), 32'(e32), 32'(e_error[0]));
    if (e_valid[0] != 0 || m_fresh[0]) begin
      check($sformatf("t%0d dir32", tick_n),    32'(d32), 32'(e_dir[0]));
      check($sformatf("t%0d period32", tick_n), p32,      32'(e_period[0]));
    end
    check($sformatf("t%0d valid8", tick_n), 32'(v8), 32'(e_valid[1]));
    check($sformatf("t%0d mode8", tick_n),  32'(m8), 32'(e_mode[1]));
    check($sformatf("t%0d color8", tick_n), 32'(c8), 32'(e_color));
    check($sformatf("t%0d error8", tick_n), 32'(e8), 32'(e_error[1]));
    if (e_valid[1] != 0 || m_fresh[1]) begin
      check($sformatf("t%0d dir8", tick_n),    32'(d8), 32'(e_dir[1]));
      check($sformatf("t%0d period8", tick_n), 32'(p8), 32'(e_period[1]));
    end
  endtask

  task automatic tick(input logic rst, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b);
    i_reset = rst;
    led_r   = r;
    led_g   = g;
    led_b   = b;
    @(posedge clk);
    #1;
    tick_n++;
    if (rst) begin
      model_reset();
      pend_s   = 0;
      pend_col = 0;
    end else begin
      model_step(pend_s, pend_col, tick_n - 1);
      pend_s   = int'(r | g | b);
      pend_col = int'({|b, |g, |r});
    end
    err32 += int'(e32);
    err8  += int'(e8);
    check_all();
  endtask

  task automatic step(input logic [3:0] p, input logic [2:0] m, input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, m[0] ? p : 4'h0, m[1] ? p : 4'h0, m[2] ? p : 4'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 4'h0, 4'h0, 4'h0);
    step(4'h0, 3'b001, 2);
  endtask

  initial begin
    int       kind, per, nst, pos, dr;
    logic [2:0] msk;

    i_reset = 1'b1;
    led_r   = '0;
    led_g   = '0;
    led_b   = '0;

    // Reset while LEDs toggle: every cycle must show reset values.
    for (int i = 0; i < 3; i++) tick(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
    check("rst valid", 32'(v32), 32'd0);
    check("rst mode", 32'(m32), 32'd3);
    step(4'h0, 3'b001, 3);

    // Red shift toward MSB, 8 clocks per step.
    for (int i = 0; i < 5; i++) step(4'(1 << (i % 4)), 3'b001, 8);
    check("shift valid", 32'(v32), 32'd1);
    check("shift mode", 32'(m32), 32'd0);
    check("shift dir", 32'(d32), 32'd1);
    check("shift period", p32, 32'd8);
    check("shift color", 32'(c32), 32'd1);

    // Green flash, 5 clocks per phase.
    do_reset(2);
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'hF : 4'h0, 3'b010, 5);
    check("flash valid", 32'(v32), 32'd1);
    check("flash mode", 32'(m32), 32'd1);
    check("flash dir", 32'(d32), 32'd0);
    check("flash period", p32, 32'd5);
    check("flash color", 32'(c32), 32'd2);

    // Blue mirror, 16 clocks per step, then the same vectors on green.
    do_reset(2);
    step(4'h0, 3'b100, 16);
    for (int i = 0; i < 6; i++) step(4'(mir[i % 3]), 3'b100, 16);
    check("mirror valid", 32'(v32), 32'd1);
    check("mirror mode", 32'(m32), 32'd2);
    check("mirror period", p32, 32'd16);
    check("mirror color", 32'(c32), 32'd4);
    err32 = 0;
    for (int i = 6; i < 9; i++) step(4'(mir[i % 3]), 3'b010, 16);
    check("mirror green valid", 32'(v32), 32'd1);
    check("mirror green color", 32'(c32), 32'd2);
    check("mirror green errors", 32'(err32), 32'd0);

    // Lock loss when the step stretches from 8 to 9 clocks, then relock at 9.
    do_reset(2);
    for (int i = 0; i < 6; i++) step(4'(1 << (i % 4)), 3'b001, 8);
    err32 = 0;
    for (int i = 6; i < 12; i++) step(4'(1 << (i % 4)), 3'b001, 9);
    check("loss error pulses", 32'(err32), 32'd1);
    check("relock valid", 32'(v32), 32'd1);
    check("relock period", p32, 32'd9);

    // Timeout on the 8-bit instance after the LEDs freeze.
    do_reset(2);
    for (int i = 0; i < 6; i++) step(4'(1 << (i % 4)), 3'b001, 8);
    err8 = 0;
    step(4'(1 << 1), 3'b001, 300);
    check("timeout valid8", 32'(v8), 32'd0);
    check("timeout mode8", 32'(m8), 32'd3);
    check("timeout error pulses8", 32'(err8), 32'd1);
    check("no timeout valid32", 32'(v32), 32'd1);
    step(4'h4, 3'b001, 8);
    step(4'h8, 3'b001, 8);
    tick(1'b1, 4'h1, 4'h0, 4'h0);
    check("acq reset valid8", 32'(v8), 32'd0);
    check("acq reset color8", 32'(c8), 32'd0);
    check("acq reset mode32", 32'(m32), 32'd3);
    step(4'h0, 3'b001, 2);

    // Random runs of every class, with colour changes and occasional resets.
    msk = 3'b001;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      per  = $urandom_range(1, 12);
      nst  = $urandom_range(3, 8);
      pos  = $urandom_range(0, 3);
      dr   = $urandom_range(0, 1);
      for (int s = 0; s < nst; s++) begin
        if ($urandom_range(0, 3) == 0) msk = 3'($urandom_range(1, 7));
        case (kind)
          0: begin
            step(4'(1 << pos), msk, per);
            pos = (dr != 0) ? (pos + 1) % 4 : (pos + 3) % 4;
          end
          1: step((s % 2 == 0) ? 4'hF : 4'h0, msk, per);
          2: step(4'(mir[(dr != 0) ? s % 3 : 2 - (s % 3)]), msk, per);
          3: step(4'($urandom), msk, $urandom_range(1, 4));
          4: step(4'(1 << pos), msk, per + (s % 2));
          default: if (s == 0) tick(1'b1, 4'($urandom), 4'h0, 4'h0);
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
